// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, state encoding and index helpers for the streaming FFT
package fft_pkg;

  localparam int CPLX_WIDTH = 16;

  typedef struct packed {
    logic signed [CPLX_WIDTH-1:0] re;
    logic signed [CPLX_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    UNLOAD
  } fft_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int bitrev(input int idx, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) begin
      r = (r << 1) | ((idx >> i) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// rtl/fft_twiddle_rom.sv - elaboration-time twiddle table, conjugated for the inverse transform
module fft_twiddle_rom import fft_pkg::*; #(
  parameter int N        = 8,
  parameter int TW_WIDTH = 16
) (
  input  logic [clog2(N)-2:0]        k,
  input  logic                       inverse,
  output logic signed [TW_WIDTH-1:0] w_real,
  output logic signed [TW_WIDTH-1:0] w_imag
);
  localparam int  HALF = N / 2;
  localparam real PI   = 3.14159265358979323846;
  localparam real AMP  = 2.0 ** (TW_WIDTH - 1) - 1.0;

  logic signed [TW_WIDTH-1:0] cos_tab [HALF];
  logic signed [TW_WIDTH-1:0] sin_tab [HALF];

  // Round half away from zero so the table is symmetric about the axes
  for (genvar g = 0; g < HALF; g++) begin : g_tab
    localparam real ANG = 2.0 * PI * real'(g) / real'(N);
    localparam real C   = AMP * $cos(ANG);
    localparam real S   = AMP * $sin(ANG);
    assign cos_tab[g] = TW_WIDTH'($rtoi(C >= 0.0 ? C + 0.5 : C - 0.5));
    assign sin_tab[g] = TW_WIDTH'($rtoi(S >= 0.0 ? S + 0.5 : S - 0.5));
  end

  assign w_real = cos_tab[k];
  assign w_imag = inverse ? sin_tab[k] : -sin_tab[k];

endmodule

// File: rtl/fft_stream_iter.sv
// rtl/fft_stream_iter.sv - iterative radix-2 DIT FFT/IFFT with streaming load and unload
module fft_stream_iter import fft_pkg::*; #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16,
  parameter int SCALE      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  input  logic                         in_inverse,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic                         out_last,
  output logic                         busy
);
  localparam int LOGN = clog2(N);
  localparam int KW   = LOGN - 1;
  localparam int SW   = clog2(LOGN);
  localparam int PW   = DATA_WIDTH + TW_WIDTH;
  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);
  localparam logic [KW-1:0]   LAST_BF  = KW'(N / 2 - 1);
  localparam logic [SW-1:0]   LAST_STG = SW'(LOGN - 1);

  fft_state_e state_q, state_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] bfly_q, bfly_d;
  logic inv_q, inv_d;
  logic signed [DATA_WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [DATA_WIDTH-1:0] mem_re_q [N];
  logic signed [DATA_WIDTH-1:0] mem_im_q [N];

  logic in_fire, out_fire, last_bfly;
  logic [LOGN-1:0] ld_addr, bf_ext, span_m, j_idx, a_idx, b_idx;
  logic [KW-1:0] k_idx;
  int unsigned s_i;

  assign in_fire   = in_valid && (state_q == LOAD);
  assign out_fire  = out_ready && (state_q == UNLOAD);
  assign last_bfly = (state_q == COMPUTE) && (stage_q == LAST_STG) && (bfly_q == LAST_BF);
  assign ld_addr   = LOGN'(bitrev(32'(cnt_q), LOGN));

  // Butterfly b of stage s pairs a = group*2*span + j with a + span, twiddle k = j*N/(2*span)
  always_comb begin
    s_i    = 32'(stage_q);
    bf_ext = LOGN'(bfly_q);
    span_m = LOGN'(1) << s_i;
    j_idx  = bf_ext & (span_m - LOGN'(1));
    a_idx  = ((bf_ext >> s_i) << (s_i + 1)) | j_idx;
    b_idx  = a_idx | span_m;
    k_idx  = KW'(j_idx << (KW - s_i));
  end

  logic signed [TW_WIDTH-1:0] w_re, w_im;

  fft_twiddle_rom #(.N(N), .TW_WIDTH(TW_WIDTH)) u_rom (
    .k      (k_idx),
    .inverse(inv_q),
    .w_real (w_re),
    .w_imag (w_im)
  );

  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [DATA_WIDTH-1:0] a_re_n, a_im_n, b_re_n, b_im_n;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0] acc_re, acc_im;
  logic signed [DATA_WIDTH:0] s_ar, s_ai, s_br, s_bi;

  always_comb begin
    a_re   = mem_re_q[a_idx];
    a_im   = mem_im_q[a_idx];
    b_re   = mem_re_q[b_idx];
    b_im   = mem_im_q[b_idx];
    p_rr   = PW'(w_re) * PW'(b_re);
    p_ii   = PW'(w_im) * PW'(b_im);
    p_ri   = PW'(w_re) * PW'(b_im);
    p_ir   = PW'(w_im) * PW'(b_re);
    acc_re = (PW + 1)'(p_rr) - (PW + 1)'(p_ii);
    acc_im = (PW + 1)'(p_ri) + (PW + 1)'(p_ir);
    // k = 0 bypasses the multiplier since +1.0 has no Q1 encoding
    t_re   = (k_idx == '0) ? b_re : DATA_WIDTH'(acc_re >>> (TW_WIDTH - 1));
    t_im   = (k_idx == '0) ? b_im : DATA_WIDTH'(acc_im >>> (TW_WIDTH - 1));
    s_ar   = (DATA_WIDTH + 1)'(a_re) + (DATA_WIDTH + 1)'(t_re);
    s_ai   = (DATA_WIDTH + 1)'(a_im) + (DATA_WIDTH + 1)'(t_im);
    s_br   = (DATA_WIDTH + 1)'(a_re) - (DATA_WIDTH + 1)'(t_re);
    s_bi   = (DATA_WIDTH + 1)'(a_im) - (DATA_WIDTH + 1)'(t_im);
    a_re_n = (SCALE != 0) ? DATA_WIDTH'(s_ar >>> 1) : DATA_WIDTH'(s_ar);
    a_im_n = (SCALE != 0) ? DATA_WIDTH'(s_ai >>> 1) : DATA_WIDTH'(s_ai);
    b_re_n = (SCALE != 0) ? DATA_WIDTH'(s_br >>> 1) : DATA_WIDTH'(s_br);
    b_im_n = (SCALE != 0) ? DATA_WIDTH'(s_bi >>> 1) : DATA_WIDTH'(s_bi);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (in_fire && cnt_q == LAST_IDX) state_d = COMPUTE;
      COMPUTE: if (last_bfly) state_d = UNLOAD;
      UNLOAD:  if (out_fire && cnt_q == LAST_IDX) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      LOAD:    in_ready = 1'b1;
      COMPUTE: busy = 1'b1;
      UNLOAD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (cnt_q == LAST_IDX);
      end
      default: ;
    endcase
  end

  assign out_real = out_re_q;
  assign out_imag = out_im_q;

  // One counter serves both load and unload addresses; it wraps to 0 at each frame edge
  always_comb begin
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    bfly_d   = bfly_q;
    inv_d    = inv_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    if (in_fire || out_fire) cnt_d = cnt_q + LOGN'(1);
    if (in_fire && cnt_q == '0) inv_d = in_inverse;
    if (state_q == COMPUTE) begin
      bfly_d = bfly_q + KW'(1);
      if (bfly_q == LAST_BF) stage_d = last_bfly ? '0 : stage_q + SW'(1);
    end
    if (last_bfly) begin
      out_re_d = mem_re_q[0];
      out_im_d = mem_im_q[0];
    end else if (out_fire) begin
      if (cnt_q == LAST_IDX) begin
        out_re_d = '0;
        out_im_d = '0;
      end else begin
        out_re_d = mem_re_q[cnt_q + LOGN'(1)];
        out_im_d = mem_im_q[cnt_q + LOGN'(1)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stage_q  <= '0;
      bfly_q   <= '0;
      inv_q    <= 1'b0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      bfly_q   <= bfly_d;
      inv_q    <= inv_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re_q[ld_addr] <= in_real;
      mem_im_q[ld_addr] <= in_imag;
    end else if (state_q == COMPUTE) begin
      mem_re_q[a_idx] <= a_re_n;
      mem_im_q[a_idx] <= a_im_n;
      mem_re_q[b_idx] <= b_re_n;
      mem_im_q[b_idx] <= b_im_n;
    end
  end

endmodule

// File: tb/tb_fft_stream_iter.sv
// tb/tb_fft_stream_iter.sv - randomized self-checking bench against a floating-point DFT model
module tb_fft_stream_iter;
  import fft_pkg::*;

  localparam int  N     = 8;
  localparam int  DW    = 16;
  localparam int  TW    = 16;
  localparam int  SCALE = 1;
  localparam int  LAT   = (N / 2) * 3;
  localparam real PI    = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_inverse;
  logic signed [DW-1:0] in_real, in_imag;
  logic out_valid, out_ready, out_last, busy;
  logic signed [DW-1:0] out_real, out_imag;

  always #5 clk = ~clk;

  fft_stream_iter #(.N(N), .DATA_WIDTH(DW), .TW_WIDTH(TW), .SCALE(SCALE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_inverse(in_inverse),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_last  (out_last),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  cplx_t xin [N];
  bit    inv_cur;
  int    exp_re [N], exp_im [N];
  int    got_re [N], got_im [N];

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // Direct DFT, scaled by 1/N to match one halving per stage over log2(N) stages
  task automatic model();
    real sr, si, ang, sgn;
    sgn = inv_cur ? 1.0 : -1.0;
    for (int k = 0; k < N; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = sgn * 2.0 * PI * real'(n * k) / real'(N);
        sr += real'(xin[n].re) * $cos(ang) - real'(xin[n].im) * $sin(ang);
        si += real'(xin[n].re) * $sin(ang) + real'(xin[n].im) * $cos(ang);
      end
      exp_re[k] = rnd(sr / real'(N));
      exp_im[k] = rnd(si / real'(N));
    end
  endtask

  task automatic fill(input int kind);
    for (int n = 0; n < N; n++) begin
      case (kind)
        0:       begin xin[n].re = (n == 0) ? 16'sd1024 : 16'sd0; xin[n].im = 16'sd0; end
        1:       begin xin[n].re = 16'sd1024; xin[n].im = 16'sd0; end
        2:       begin xin[n].re = (n % 2 == 0) ? 16'sd1024 : -16'sd1024; xin[n].im = 16'sd0; end
        3:       begin xin[n].re = (n == 1) ? 16'sd1024 : 16'sd0; xin[n].im = 16'sd0; end
        default: begin
          xin[n].re = 16'(int'($urandom_range(0, 4000)) - 2000);
          xin[n].im = 16'(int'($urandom_range(0, 4000)) - 2000);
        end
      endcase
    end
  endtask

  // Starts and ends on a falling edge
  task automatic run_frame(input string name, input bit gaps, input bit stall, input bit junk,
                           input int tol);
    int guard, lat, idx, prev_re, prev_im;
    bit prev_stall, rdy_bad;
    model();
    for (int n = 0; n < N; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk);
          @(negedge clk);
        end
      end
      in_valid   = 1'b1;
      in_real    = xin[n].re;
      in_imag    = xin[n].im;
      in_inverse = (n == 0) ? inv_cur : 1'($urandom_range(0, 1));
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check_val({name, " in_ready_timeout"}, 0, 1, 0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check_val({name, " busy_compute"}, int'(busy), 1, 0);
    check_val({name, " in_ready_compute"}, int'(in_ready), 0, 0);
    if (junk) begin
      in_valid   = 1'b1;
      in_real    = 16'($urandom);
      in_imag    = 16'($urandom);
      in_inverse = 1'($urandom_range(0, 1));
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check_val({name, " latency"}, lat, LAT, 0);
    if (!out_valid) return;
    idx = 0;
    guard = 0;
    prev_stall = 1'b0;
    rdy_bad = 1'b0;
    prev_re = 0;
    prev_im = 0;
    while (idx < N && guard < 400) begin
      guard++;
      if (!out_valid) begin
        check_val($sformatf("%s out_valid[%0d]", name, idx), 0, 1, 0);
        in_valid = 1'b0;
        return;
      end
      if (in_ready) rdy_bad = 1'b1;
      if (prev_stall) begin
        check_val($sformatf("%s hold_re[%0d]", name, idx), int'(out_real), prev_re, 0);
        check_val($sformatf("%s hold_im[%0d]", name, idx), int'(out_imag), prev_im, 0);
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (junk) in_real = 16'($urandom);
      if (out_ready) begin
        got_re[idx] = int'(out_real);
        got_im[idx] = int'(out_imag);
        check_val($sformatf("%s last[%0d]", name, idx), int'(out_last), int'(idx == N - 1), 0);
        idx++;
        if (idx == N) in_valid = 1'b0;
      end
      prev_stall = !out_ready;
      prev_re    = int'(out_real);
      prev_im    = int'(out_imag);
      @(posedge clk);
      @(negedge clk);
    end
    check_val({name, " beats"}, idx, N, 0);
    check_val({name, " in_ready_unload"}, int'(rdy_bad), 0, 0);
    check_val({name, " out_valid_after"}, int'(out_valid), 0, 0);
    check_val({name, " out_last_after"}, int'(out_last), 0, 0);
    check_val({name, " in_ready_after"}, int'(in_ready), 1, 0);
    check_val({name, " busy_after"}, int'(busy), 0, 0);
    for (int k = 0; k < idx; k++) begin
      check_val($sformatf("%s X[%0d].re", name, k), got_re[k], exp_re[k], tol);
      check_val($sformatf("%s X[%0d].im", name, k), got_im[k], exp_im[k], tol);
    end
  endtask

  task automatic check_reset_state(input string name);
    check_val({name, " in_ready"}, int'(in_ready), 1, 0);
    check_val({name, " out_valid"}, int'(out_valid), 0, 0);
    check_val({name, " out_last"}, int'(out_last), 0, 0);
    check_val({name, " busy"}, int'(busy), 0, 0);
    check_val({name, " out_real"}, int'(out_real), 0, 0);
    check_val({name, " out_imag"}, int'(out_imag), 0, 0);
  endtask

  // mid_compute = 0 aborts after three load beats, 1 aborts at compute cycle 5
  task automatic abort_frame(input string name, input bit mid_compute);
    int beats;
    beats = mid_compute ? N : 3;
    for (int n = 0; n < beats; n++) begin
      in_valid   = 1'b1;
      in_real    = 16'($urandom);
      in_imag    = 16'($urandom);
      in_inverse = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (mid_compute) begin
      repeat (4) begin
        @(posedge clk);
        @(negedge clk);
      end
      check_val({name, " busy_before"}, int'(busy), 1, 0);
    end
    rst_n = 1'b0;
    #1;
    check_reset_state(name);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_real    = '0;
    in_imag    = '0;
    in_inverse = 1'b0;
    out_ready  = 1'b0;
    inv_cur    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fill(0); inv_cur = 1'b0; run_frame("impulse", 1'b0, 1'b0, 1'b0, 0);
    fill(1); inv_cur = 1'b0; run_frame("dc", 1'b0, 1'b0, 1'b0, 0);
    fill(2); inv_cur = 1'b0; run_frame("nyquist", 1'b0, 1'b0, 1'b0, 0);
    fill(3); inv_cur = 1'b1; run_frame("ifft_bin1", 1'b0, 1'b0, 1'b0, 2);
    fill(3); inv_cur = 1'b0; run_frame("fft_bin1", 1'b0, 1'b0, 1'b0, 2);
    fill(0); inv_cur = 1'b0; run_frame("impulse_bp", 1'b1, 1'b1, 1'b1, 0);
    for (int f = 0; f < 6; f++) begin
      fill(4);
      inv_cur = 1'($urandom_range(0, 1));
      run_frame($sformatf("random%0d", f), 1'b1, 1'b1, 1'b1, 4);
    end
    abort_frame("rst_compute", 1'b1);
    fill(1); inv_cur = 1'b0; run_frame("dc_after_rst_compute", 1'b0, 1'b0, 1'b0, 0);
    abort_frame("rst_load", 1'b0);
    fill(1); inv_cur = 1'b0; run_frame("dc_after_rst_load", 1'b1, 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_stream_iter.md
Name: fft_stream_iter

Overview:
- Parametrised, iterative radix-2 decimation-in-time FFT/IFFT with ready/valid streaming on input and output.
- Accepts N complex samples in natural order and stores them bit-reversed in an internal buffer.
- Runs log2(N) butterfly stages at one butterfly per cycle, with optional per-stage 1/2 scaling, then streams N results out in natural order.
- Sits in the signal_processing path and replaces the single-cycle fixed-size FFT block.

Parameters:
- N, 8, transform size; power of 2, 4..1024.
- DATA_WIDTH, 16, signed sample width per real/imag component.
- TW_WIDTH, 16, signed twiddle width, Q1.(TW_WIDTH-1).
- SCALE, 1, 1 = arithmetic shift right by 1 after every stage; 0 = no scaling, results wrap modulo 2^DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_real  in  DATA_WIDTH  signed real input.
- in_imag  in  DATA_WIDTH  signed imaginary input.
- in_inverse  in  1  mode select; 1 = IFFT; sampled on the first beat of a frame only.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_real  out  DATA_WIDTH  signed real result.
- out_imag  out  DATA_WIDTH  signed imaginary result.
- out_last  out  1  high with the N-th output beat.
- busy  out  1  high in COMPUTE and UNLOAD.

Behaviour:
- Interface fixed: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, sync deassert expected): state = LOAD, counters = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_real = out_imag = 0.
  - Buffer contents are undefined.
- FSM transitions:
  - LOAD → COMPUTE: after beat N-1 is accepted.
  - COMPUTE → UNLOAD: after the last butterfly.
  - UNLOAD → LOAD: after the out_last beat is accepted.
- LOAD:
  - in_ready = 1. A beat transfers when in_valid && in_ready.
  - Beat n is written to address bitrev(n).
  - in_inverse is latched at n = 0 and ignored on later beats.
- COMPUTE:
  - in_ready = 0, out_valid = 0.
  - Stages s = 0..log2(N)-1; span = 2^s; N/2 butterflies per stage, one per cycle.
  - Duration is exactly (N/2)*log2(N) cycles: 12 for N = 8.
  - Butterfly on (a, b) with twiddle index k = j*(N/(2*span)):
    - t = W_k*b.
    - a' = a + t, b' = a - t.
  - Forward: W_k = cos - j·sin(2πk/N). Inverse: conjugate twiddle; there is no 1/N factor beyond SCALE.
  - Products are DATA_WIDTH+TW_WIDTH wide, then arithmetic shift right by TW_WIDTH-1 (truncation).
  - Sums are formed at DATA_WIDTH+1 bits.
    - SCALE = 1: result = sum >>> 1.
    - SCALE = 0: result = low DATA_WIDTH bits of sum.
  - k = 0 is a trivial butterfly: t = b exactly, no multiply. This avoids +1.0 being unrepresentable.
  - Twiddle ROM entries: round(±(2^(TW_WIDTH-1)-1)·cos/sin), computed at elaboration.
- UNLOAD:
  - out_valid = 1; address counts 0..N-1 and advances only on out_valid && out_ready.
  - out_real/out_imag are registered and hold stable while stalled.
  - out_last = 1 only on address N-1.
  - After the final beat: out_valid and out_last drop in the next cycle and in_ready rises in that same cycle. No bubble beyond one cycle.
- First output is valid on the cycle after the last COMPUTE cycle.
- Holding in_valid high during COMPUTE/UNLOAD has no effect; samples are taken only in LOAD.
- rst_n low mid-frame (any state) aborts immediately and returns to the reset values. The next frame behaves as if fresh.
- Back-to-back frames: a new frame can begin the cycle after out_last is accepted.

Decomposition:
- Shared package fft_pkg holds:
  - typedef for a complex sample (real/imag, DATA_WIDTH);
  - function clog2;
  - function bitrev(idx, bits);
  - state enum {LOAD, COMPUTE, UNLOAD}.
- One sub-module: fft_twiddle_rom (params N, TW_WIDTH; input k, inverse; outputs w_real, w_imag; combinational, contents fixed at elaboration).
- Butterfly arithmetic stays inline.

Test Plan (N=8, DATA_WIDTH=16, TW_WIDTH=16, SCALE=1):
- Impulse: x[0] = 1024, others 0, forward → all 8 outputs (128, 0), out_last on beat 7, first out_valid 12 cycles after the last input beat.
- DC: all x = (1024, 0) → X[0] = (1024, 0), X[1..7] = (0, 0) exactly.
- Nyquist: x alternating +1024/-1024 → X[4] = (1024, 0), all others (0, 0).
- Inverse: input only X[1] = (1024, 0), in_inverse = 1 → x[0] ≈ (128, 0), x[2] ≈ (0, +128), x[4] ≈ (-128, 0), x[6] ≈ (0, -128), within ±2 LSB. The same input forward gives x[2] ≈ (0, -128).
- Backpressure: out_ready toggled randomly → output sequence identical to the impulse case and held stable while stalled. in_ready stays 0 until the cycle after out_last is accepted.
- Reset mid-COMPUTE: rst_n low for 1 cycle at compute cycle 5 → in_ready = 1, out_valid = 0, busy = 0 immediately. A following DC frame yields X[0] = (1024, 0).
